// File: rtl/fetch_addr_gen.sv
// Fetch address generator: issues sequential word-aligned PCs into the address FIFO,
// redirects on jump/JTAG reset with a FIFO flush, and throttles issue with in-flight credits.
module fetch_addr_gen #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jump_flag_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             jtag_reset_flag_i,
    input  logic             addr_fifo_full,
    output logic [31:0]      addr_fifo_w,
    output logic             addr_fifo_wen,
    output logic             addr_fifo_rstn,
    input  logic             inst_pop_i,
    output logic [31:0]      pc_o,
    output logic [CNT_W-1:0] inflight_o
);

    localparam logic [CNT_W-1:0] MaxInflight = CNT_W'(MAX_INFLIGHT);

    typedef enum logic [0:0] {
        StFlush,
        StRun
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             rstn_q;
    logic             redirect;
    logic             wen;

    assign redirect = jump_flag_i | jtag_reset_flag_i;
    assign wen      = (state_q == StRun) & ~addr_fifo_full & (inflight_q < MaxInflight) &
                      ~redirect;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = inflight_q;

        case (state_q)
            StFlush: begin
                // Credits stay cleared and pops are ignored until the flush completes.
                inflight_d = '0;
                if (!redirect) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (redirect) begin
                    state_d = StFlush;
                end else if (wen && !inst_pop_i) begin
                    inflight_d = inflight_q + 1'b1;
                end else if (inst_pop_i && !wen && (inflight_q != '0)) begin
                    inflight_d = inflight_q - 1'b1;
                end
            end
            default: state_d = StFlush;
        endcase

        // Outstanding fetches are discarded downstream on redirect, so their credits vanish.
        if (redirect) begin
            inflight_d = '0;
        end

        if (jtag_reset_flag_i) begin
            pc_d = RESET_PC;
        end else if (jump_flag_i) begin
            pc_d = jump_addr_i & 32'hFFFF_FFFC;
        end else if (wen) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFlush;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            rstn_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            rstn_q     <= (state_d == StRun);
        end
    end

    assign addr_fifo_w    = pc_q;
    assign addr_fifo_wen  = wen;
    assign addr_fifo_rstn = rstn_q;
    assign pc_o           = pc_q;
    assign inflight_o     = inflight_q;

endmodule

// File: tb/tb_fetch_addr_gen.sv
// Bench for fetch_addr_gen: directed vector table for the documented scenarios, an async
// reset probe, then random traffic against a cycle-level reference model.
module tb_fetch_addr_gen;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          MAX    = 8;

    logic        clk;
    logic        rst_n;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        jtag_rst;
    logic        full;
    logic [31:0] fifo_w;
    logic        fifo_wen;
    logic        fifo_rstn;
    logic        pop;
    logic [31:0] pc;
    logic [7:0]  inflight;

    fetch_addr_gen #(
        .RESET_PC    (RST_PC),
        .MAX_INFLIGHT(MAX),
        .CNT_W       (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .jump_flag_i      (jump_flag),
        .jump_addr_i      (jump_addr),
        .jtag_reset_flag_i(jtag_rst),
        .addr_fifo_full   (full),
        .addr_fifo_w      (fifo_w),
        .addr_fifo_wen    (fifo_wen),
        .addr_fifo_rstn   (fifo_rstn),
        .inst_pop_i       (pop),
        .pc_o             (pc),
        .inflight_o       (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: "running" flag, next PC and number of outstanding addresses.
    bit          m_run;
    logic [31:0] m_pc;
    int          m_inf;

    typedef struct {
        logic        jump;
        logic [31:0] jaddr;
        logic        jtag;
        logic        full;
        logic        pop;
        logic        e_wen;
        logic [31:0] e_w;
        logic        e_rstn;
        int          e_inf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic j, input logic [31:0] ja, input logic jt, input logic fu,
                       input logic po, input logic ew, input logic [31:0] eaddr,
                       input logic er, input int ei);
        vec_t v;
        v.jump = j; v.jaddr = ja; v.jtag = jt; v.full = fu; v.pop = po;
        v.e_wen = ew; v.e_w = eaddr; v.e_rstn = er; v.e_inf = ei;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic j, input logic [31:0] ja, input logic jt,
                         input logic fu, input logic po);
        jump_flag = j; jump_addr = ja; jtag_rst = jt; full = fu; pop = po;
    endtask

    function automatic logic model_wen();
        return m_run && !full && (m_inf < MAX) && !jump_flag && !jtag_rst;
    endfunction

    task automatic model_reset();
        m_run = 1'b0; m_pc = RST_PC; m_inf = 0;
    endtask

    // Called mid-cycle with inputs stable.
    task automatic check_model();
        check("model_wen", {31'd0, fifo_wen}, {31'd0, model_wen()});
        check("model_addr", fifo_w, m_pc);
        check("model_pc", pc, m_pc);
        check("model_rstn", {31'd0, fifo_rstn}, {31'd0, m_run});
        check("model_inflight", {24'd0, inflight}, m_inf);
    endtask

    // Advance one clock and update the model with the pre-edge inputs.
    task automatic advance();
        logic w;
        @(posedge clk);
        w = model_wen();
        if (jump_flag || jtag_rst) begin
            m_pc  = jtag_rst ? RST_PC : {jump_addr[31:2], 2'b00};
            m_inf = 0;
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
        end else begin
            if (w) m_pc = m_pc + 32'd4;
            if (w && !pop) m_inf++;
            else if (pop && !w && m_inf > 0) m_inf--;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        apply(0, 32'h0, 0, 0, 0);
        model_reset();

        // Reset release, 8 credits of streaming, credit return.
        add(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 0, 1, 32'(4 * i), 1, i);
        add(0, 0, 0, 0, 0, 0, 32'h20, 1, 8);
        add(0, 0, 0, 0, 1, 0, 32'h20, 1, 8);
        add(0, 0, 0, 0, 0, 1, 32'h20, 1, 7);
        add(0, 0, 0, 0, 1, 0, 32'h24, 1, 8);
        add(0, 0, 0, 0, 1, 1, 32'h24, 1, 7);
        add(0, 0, 0, 0, 0, 1, 32'h28, 1, 7);
        add(0, 0, 0, 0, 1, 0, 32'h2C, 1, 8);
        add(0, 0, 0, 0, 1, 1, 32'h2C, 1, 7);
        // Two-cycle jump, unaligned second target.
        add(1, 32'h100, 0, 0, 0, 0, 32'h30, 1, 7);
        add(1, 32'h203, 0, 0, 0, 0, 32'h100, 0, 0);
        add(0, 0, 0, 0, 0, 0, 32'h200, 0, 0);
        add(0, 0, 0, 0, 0, 1, 32'h200, 1, 0);
        add(0, 0, 0, 0, 0, 1, 32'h204, 1, 1);
        // Full backpressure at 0x40.
        add(1, 32'h40, 0, 0, 0, 0, 32'h208, 1, 2);
        add(0, 0, 0, 0, 0, 0, 32'h40, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 0, 0, 32'h40, 1, 0);
        add(0, 0, 0, 0, 0, 1, 32'h40, 1, 0);
        // Address wrap.
        add(1, 32'hFFFF_FFF8, 0, 0, 0, 0, 32'h44, 1, 1);
        add(0, 0, 0, 0, 0, 0, 32'hFFFF_FFF8, 0, 0);
        add(0, 0, 0, 0, 0, 1, 32'hFFFF_FFF8, 1, 0);
        add(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 1);
        add(0, 0, 0, 0, 0, 1, 32'h0, 1, 2);
        // Jump and JTAG together: JTAG wins.
        add(1, 32'h80, 1, 0, 0, 0, 32'h4, 1, 3);
        add(0, 0, 0, 0, 0, 0, RST_PC, 0, 0);
        add(0, 0, 0, 0, 0, 1, RST_PC, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_wen", {31'd0, fifo_wen}, 32'd0);
        check("reset_rstn", {31'd0, fifo_rstn}, 32'd0);
        check("reset_addr", fifo_w, RST_PC);
        check("reset_inflight", {24'd0, inflight}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            apply(vecs[k].jump, vecs[k].jaddr, vecs[k].jtag, vecs[k].full, vecs[k].pop);
            @(negedge clk);
            check_model();
            check($sformatf("vec%0d_wen", k), {31'd0, fifo_wen}, {31'd0, vecs[k].e_wen});
            check($sformatf("vec%0d_addr", k), fifo_w, vecs[k].e_w);
            check($sformatf("vec%0d_rstn", k), {31'd0, fifo_rstn}, {31'd0, vecs[k].e_rstn});
            check($sformatf("vec%0d_inflight", k), {24'd0, inflight}, vecs[k].e_inf);
            advance();
        end

        // Async reset mid-cycle: outputs must drop before any clock edge.
        apply(0, 0, 0, 0, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_wen", {31'd0, fifo_wen}, 32'd0);
        check("async_rstn", {31'd0, fifo_rstn}, 32'd0);
        check("async_addr", fifo_w, RST_PC);
        check("async_pc", pc, RST_PC);
        check("async_inflight", {24'd0, inflight}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 63) == 0,
                  $urandom_range(0, 3) == 0,
                  (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            @(negedge clk);
            check_model();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
